dostring_frame_sched: RTL and testbench
=======================================

DOSTRING_FRAME_SCHED -- requirements
Module: dostring_frame_sched

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 60, strip length in pixels (1..255).
REQ-002 SHALL have parameter CLK_DIV, default 4, SCK half-period in dostring_clk cycles (>=1).
REQ-003 SHALL have parameter REFRESH_CYCLES, default 1000000, auto-refresh interval in cycles.
REQ-004 SHALL have port dostring_clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port dostring_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request for one frame.
REQ-007 SHALL have port auto_refresh  input  1  level; enables periodic frames.
REQ-008 SHALL have port pix_req  output  1  pixel fetch request.
REQ-009 SHALL have port pix_idx  output  8  pixel index being fetched.
REQ-010 SHALL have port pix_ack  input  1  pixel data valid this cycle.
REQ-011 SHALL have port pix_bright  input  5  global brightness for pixel.
REQ-012 SHALL have ports pix_blue, pix_green, pix_red  input  8 each  colour data.
REQ-013 SHALL have ports mosi, sck  output  1 each  SPI to the strip.
REQ-014 SHALL have ports busy (level) and frame_done (one-cycle pulse)  output  1 each.

Function
REQ-015 SHALL implement states IDLE, START_FRM, PIX_REQ, PIX_SEND, END_FRM, DONE.
REQ-016 IDLE -> START_FRM on start=1, or on auto_refresh=1 with refresh timer == REFRESH_CYCLES-1; simultaneous start and timer expiry SHALL launch exactly one frame.
REQ-017 START_FRM SHALL send 4 bytes 0x00, then enter PIX_REQ with pix_idx=0.
REQ-018 PIX_REQ SHALL hold pix_req=1 and pix_idx stable until pix_ack=1; data SHALL be captured on the ack cycle, pix_req deasserts the next cycle; pix_ack outside PIX_REQ SHALL be ignored.
REQ-019 PIX_SEND SHALL send bytes {3'b111,pix_bright}, blue, green, red in that order; then pix_idx+1 -> PIX_REQ, or after pix_idx==NUM_LEDS-1 -> END_FRM.
REQ-020 END_FRM SHALL send max(4, ceil(NUM_LEDS/16)) bytes 0xFF, then DONE.
REQ-021 DONE SHALL pulse frame_done for one cycle, clear the refresh timer, return to IDLE.
REQ-022 SPI mode 0, MSB first; sck idle low; mosi changes only while sck low; each bit = CLK_DIV cycles low then CLK_DIV cycles high.
REQ-023 Bytes within START_FRM, PIX_SEND and END_FRM SHALL be back-to-back (no extra sck-low cycles); gaps allowed only while waiting in PIX_REQ.
REQ-024 Latency: start at cycle T -> busy=1 at T+1, first mosi bit valid at T+2, first sck rise at T+2+CLK_DIV.
REQ-025 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-026 Refresh timer SHALL count in IDLE only when auto_refresh=1, saturate at REFRESH_CYCLES-1, and reset to 0 when auto_refresh=0.

Reset
REQ-027 On dostring_reset=0, immediately: state IDLE, sck=0, mosi=0, pix_req=0, pix_idx=0, busy=0, frame_done=0, timer=0, also mid-frame.
REQ-028 After reset release, no frame SHALL start without a new start or a full refresh interval.

Structure
REQ-029 Package dostring_pkg SHALL hold state enum, LED header 3'b111, START_BYTE 8'h00, END_BYTE 8'hFF.
REQ-030 Sub-module dostring_spi_byte SHALL serialise one byte per load/ready handshake (parameter CLK_DIV); sequencer and timers stay in dostring_frame_sched.

Verification
REQ-031 NUM_LEDS=2, CLK_DIV=1, start pulse, pix_ack immediate with bright=5'h1F, B/G/R=0x11/0x22/0x33 -> mosi bytes 00 00 00 00 FF 11 22 33 FF 11 22 33 FF FF FF FF, 128 sck pulses, one frame_done.
REQ-032 pix_ack delayed 10 cycles per pixel -> pix_idx stable and pix_req high throughout wait, sck low during gap, byte stream unchanged.
REQ-033 Reset asserted mid-PIX_SEND -> sck=0, mosi=0, busy=0 same cycle; no frame_done; new start after release yields full correct frame.
REQ-034 auto_refresh=1, REFRESH_CYCLES=100, NUM_LEDS=1 -> frame_done pulses repeat, IDLE interval exactly 100 cycles; start in the expiry cycle -> one frame only.
REQ-035 start pulses while busy -> ignored; NUM_LEDS=60, CLK_DIV=4 -> 1984 sck pulses, 4 end bytes.

Source files
------------

// File: rtl/dostring_pkg.sv
// Shared types and constants for the LED-strip frame scheduler.
package dostring_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FRM,
        PIX_REQ,
        PIX_SEND,
        END_FRM,
        DONE
    } state_t;

    localparam logic [2:0] LED_HEADER = 3'b111;
    localparam logic [7:0] START_BYTE = 8'h00;
    localparam logic [7:0] END_BYTE   = 8'hFF;

    // Trailing 0xFF bytes: enough clock edges to push data through the whole strip.
    function automatic int unsigned end_byte_count(input int unsigned num_leds);
        int unsigned n;
        n = (num_leds + 16'd15) / 16'd16;
        return (n > 4) ? n : 4;
    endfunction

endpackage

// File: rtl/dostring_spi_byte.sv
// SPI mode-0 byte serialiser, MSB first. A new byte is accepted on load&&ready;
// ready rises during the final high-phase cycle so consecutive bytes run with no gap.
module dostring_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       idle,
    output logic       mosi,
    output logic       sck
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

    logic          active;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          phase_end;

    assign phase_end = (div_cnt == DMAX);
    assign ready     = !active || (sck && phase_end && (bit_cnt == 3'd7));
    assign idle      = !active;
    assign mosi      = shreg[7];

    // Bit timing: CLK_DIV cycles low then CLK_DIV cycles high per bit; data shifts on the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (load && ready) begin
            active  <= 1'b1;
            shreg   <= data;
            bit_cnt <= '0;
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (active) begin
            if (phase_end) begin
                div_cnt <= '0;
                if (!sck) begin
                    sck <= 1'b1;
                end else begin
                    sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/dostring_frame_sched.sv
// Frame sequencer for an APA102-style LED strip: start frame, per-pixel fetch
// and send, end frame, plus an optional periodic auto-refresh timer.
module dostring_frame_sched
    import dostring_pkg::*;
#(
    parameter int NUM_LEDS       = 60,
    parameter int CLK_DIV        = 4,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic       dostring_clk,
    input  logic       dostring_reset,
    input  logic       start,
    input  logic       auto_refresh,
    output logic       pix_req,
    output logic [7:0] pix_idx,
    input  logic       pix_ack,
    input  logic [4:0] pix_bright,
    input  logic [7:0] pix_blue,
    input  logic [7:0] pix_green,
    input  logic [7:0] pix_red,
    output logic       mosi,
    output logic       sck,
    output logic       busy,
    output logic       frame_done
);

    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(REFRESH_CYCLES - 1);
    localparam logic [4:0]    END_LAST = 5'(end_byte_count(NUM_LEDS) - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_LEDS - 1);

    state_t        state, state_next;
    logic [4:0]    byte_cnt;
    logic [TW-1:0] timer;
    logic [4:0]    cap_bright;
    logic [7:0]    cap_blue, cap_green, cap_red;
    logic          launch;
    logic          spi_load, spi_ready, spi_idle;
    logic [7:0]    spi_data;

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign pix_req    = (state == PIX_REQ);

    dostring_spi_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_spi (
        .clk  (dostring_clk),
        .rst_n(dostring_reset),
        .load (spi_load),
        .data (spi_data),
        .ready(spi_ready),
        .idle (spi_idle),
        .mosi (mosi),
        .sck  (sck)
    );

    // State register.
    always_ff @(posedge dostring_clk or negedge dostring_reset) begin
        if (!dostring_reset) state <= IDLE;
        else                 state <= state_next;
    end

    // Next state and byte selection; a byte is handed to the serialiser whenever it is ready.
    always_comb begin
        state_next = state;
        spi_load   = 1'b0;
        spi_data   = START_BYTE;
        launch     = start || (auto_refresh && (timer == TMAX));
        case (state)
            IDLE: begin
                if (launch) state_next = START_FRM;
            end
            START_FRM: begin
                spi_load = spi_ready;
                if (spi_ready && (byte_cnt == 5'd3)) state_next = PIX_REQ;
            end
            PIX_REQ: begin
                if (pix_ack) state_next = PIX_SEND;
            end
            PIX_SEND: begin
                spi_load = spi_ready;
                case (byte_cnt[1:0])
                    2'd0:    spi_data = {LED_HEADER, cap_bright};
                    2'd1:    spi_data = cap_blue;
                    2'd2:    spi_data = cap_green;
                    default: spi_data = cap_red;
                endcase
                if (spi_ready && (byte_cnt == 5'd3))
                    state_next = (pix_idx == LAST_IDX) ? END_FRM : PIX_REQ;
            end
            END_FRM: begin
                spi_data = END_BYTE;
                // All end bytes are queued first, then DONE waits for the last one to finish shifting.
                if (byte_cnt <= END_LAST) spi_load = spi_ready;
                else if (spi_idle)        state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte counter, pixel index and pixel capture.
    always_ff @(posedge dostring_clk or negedge dostring_reset) begin
        if (!dostring_reset) begin
            byte_cnt   <= '0;
            pix_idx    <= '0;
            cap_bright <= '0;
            cap_blue   <= '0;
            cap_green  <= '0;
            cap_red    <= '0;
        end else begin
            if (state != state_next) byte_cnt <= '0;
            else if (spi_load)       byte_cnt <= byte_cnt + 5'd1;

            if ((state == IDLE) && (state_next == START_FRM))
                pix_idx <= '0;
            else if ((state == PIX_SEND) && (state_next == PIX_REQ))
                pix_idx <= pix_idx + 8'd1;

            if ((state == PIX_REQ) && pix_ack) begin
                cap_bright <= pix_bright;
                cap_blue   <= pix_blue;
                cap_green  <= pix_green;
                cap_red    <= pix_red;
            end
        end
    end

    // Refresh timer: counts only while idle with auto_refresh set, saturates, cleared by DONE.
    always_ff @(posedge dostring_clk or negedge dostring_reset) begin
        if (!dostring_reset)                        timer <= '0;
        else if (!auto_refresh || (state == DONE)) timer <= '0;
        else if ((state == IDLE) && (timer != TMAX)) timer <= timer + TW'(1);
    end

endmodule

// File: tb/tb_dostring_frame_sched.sv
// Scoreboard bench: expected SPI bytes are queued as frames and pixels are issued;
// a bit monitor reassembles mosi on each sck rise and pops/compares.
module tb_dostring_frame_sched;

    localparam int N_A   = 2;
    localparam int DIV_A = 1;
    localparam int REF_A = 100;
    localparam int END_A = ((N_A + 15) / 16 > 4) ? (N_A + 15) / 16 : 4;
    localparam int N_B   = 60;
    localparam int DIV_B = 4;
    localparam int END_B = ((N_B + 15) / 16 > 4) ? (N_B + 15) / 16 : 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, auto_a, ack_a, req_a, mosi_a, sck_a, busy_a, done_a;
    logic [4:0] bright_a;
    logic [7:0] blue_a, green_a, red_a, idx_a;
    logic       start_b, ack_b, req_b, mosi_b, sck_b, busy_b, done_b;
    logic [7:0] idx_b;

    assign ack_b = req_b;

    dostring_frame_sched #(
        .NUM_LEDS(N_A), .CLK_DIV(DIV_A), .REFRESH_CYCLES(REF_A)
    ) dut_a (
        .dostring_clk(clk), .dostring_reset(rst_n), .start(start_a), .auto_refresh(auto_a),
        .pix_req(req_a), .pix_idx(idx_a), .pix_ack(ack_a), .pix_bright(bright_a),
        .pix_blue(blue_a), .pix_green(green_a), .pix_red(red_a),
        .mosi(mosi_a), .sck(sck_a), .busy(busy_a), .frame_done(done_a)
    );

    dostring_frame_sched #(
        .NUM_LEDS(N_B), .CLK_DIV(DIV_B), .REFRESH_CYCLES(1000)
    ) dut_b (
        .dostring_clk(clk), .dostring_reset(rst_n), .start(start_b), .auto_refresh(1'b0),
        .pix_req(req_b), .pix_idx(idx_b), .pix_ack(ack_b), .pix_bright(5'h0A),
        .pix_blue(8'h01), .pix_green(8'h02), .pix_red(8'h5A),
        .mosi(mosi_b), .sck(sck_b), .busy(busy_b), .frame_done(done_b)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         exp_idx = 0;
    int         ack_delay = 0;
    bit         fixed_data = 1'b1;
    int         frames_a = 0;
    int         exp_frames_a = 0;
    int         frames_b = 0;
    int         sck_cnt_b = 0;
    logic [39:0] last_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_header();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        exp_idx = 0;
        exp_frames_a++;
    endtask

    // Byte monitor and frame_done checks for instance A.
    logic       prev_sck_a = 1'b0, prev_done_a = 1'b0;
    logic [7:0] sh_a = '0;
    int         bits_a = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            bits_a = 0; prev_sck_a = 1'b0; prev_done_a = 1'b0;
        end else begin
            if (sck_a && !prev_sck_a) begin
                sh_a = {sh_a[6:0], mosi_a};
                bits_a++;
                if (bits_a == 8) begin
                    bits_a = 0;
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_byte: got %02h, no byte expected", sh_a);
                    end else begin
                        check("byte_a", {24'd0, sh_a}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
            prev_sck_a = sck_a;
            if (done_a) begin
                frames_a++;
                check("done_one_cycle", {31'd0, prev_done_a}, 32'd0);
                check("queue_empty_at_done", exp_q.size(), 32'd0);
                check("bits_at_done", bits_a, 32'd0);
            end
            prev_done_a = done_a;
        end
    end

    // Bit/frame monitor for instance B.
    logic       prev_sck_b = 1'b0;
    logic [7:0] sh_b = '0;
    int         bits_b = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sck_b && !prev_sck_b) begin
                sck_cnt_b++;
                sh_b = {sh_b[6:0], mosi_b};
                bits_b++;
                if (bits_b == 8) begin
                    bits_b = 0;
                    last_b = {last_b[31:0], sh_b};
                end
            end
            prev_sck_b = sck_b;
            if (done_b) frames_b++;
        end
    end

    // Pixel responder for instance A: waits ack_delay cycles (or random), then acks with data.
    task automatic serve_pixel();
        int d;
        logic [4:0] br;
        logic [7:0] b, g, r;
        d = (ack_delay < 0) ? int'($urandom_range(0, 24)) : ack_delay;
        ack_a = 1'b0;
        check("pix_idx", {24'd0, idx_a}, exp_idx);
        for (int k = 0; k < d; k++) begin
            check("req_held", {31'd0, req_a}, 32'd1);
            check("idx_stable", {24'd0, idx_a}, exp_idx);
            if (k >= 16 * DIV_A) check("sck_low_gap", {31'd0, sck_a}, 32'd0);
            @(negedge clk);
            if (!rst_n) return;
        end
        if (fixed_data) begin
            br = 5'h1F; b = 8'h11; g = 8'h22; r = 8'h33;
        end else begin
            br = 5'($urandom); b = 8'($urandom); g = 8'($urandom); r = 8'($urandom);
        end
        ack_a = 1'b1; bright_a = br; blue_a = b; green_a = g; red_a = r;
        exp_q.push_back({3'b111, br});
        exp_q.push_back(b);
        exp_q.push_back(g);
        exp_q.push_back(r);
        exp_idx++;
        if (exp_idx == N_A) begin
            for (int i = 0; i < END_A; i++) exp_q.push_back(8'hFF);
            exp_idx = 0;
        end
        @(negedge clk);
        ack_a = 1'b0;
        bright_a = 5'($urandom); blue_a = 8'($urandom); green_a = 8'($urandom); red_a = 8'($urandom);
        if (rst_n) check("req_drop", {31'd0, req_a}, 32'd0);
    endtask

    initial begin
        ack_a = 1'b0; bright_a = '0; blue_a = '0; green_a = '0; red_a = '0;
        forever begin
            @(negedge clk);
            if (rst_n && req_a) begin
                serve_pixel();
            end else begin
                // Spurious acks outside PIX_REQ must not be captured.
                ack_a = ($urandom_range(0, 3) == 0);
                bright_a = 5'($urandom); blue_a = 8'($urandom); green_a = 8'($urandom); red_a = 8'($urandom);
            end
        end
    end

    task automatic wait_done_a(input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            got = done_a;
        end
        check("frame_done_a_seen", {31'd0, got}, 32'd1);
    endtask

    // Called in the DONE cycle; measures idle cycles until busy rises again.
    task automatic measure_gap(input bit start_at_expiry, output int gap);
        gap = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 0) push_header();
            if (start_at_expiry && c == REF_A - 1) start_a = 1'b1;
            if (busy_a) begin
                start_a = 1'b0;
                break;
            end
            gap++;
        end
        start_a = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, busy_seen;
        bit got;
        rst_n = 1'b0; start_a = 1'b0; auto_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sck", {31'd0, sck_a}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_req", {31'd0, req_a}, 32'd0);
        check("rst_idx", {24'd0, idx_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_idx_b", {24'd0, idx_b}, 32'd0);
        rst_n = 1'b1;

        busy_seen = 0;
        repeat (20) begin @(negedge clk); busy_seen += int'(busy_a); end
        check("no_spontaneous_frame", busy_seen, 32'd0);

        // Reference frame with immediate ack and fixed colours; latency of busy and first sck rise.
        ack_delay = 0; fixed_data = 1'b1;
        @(negedge clk);
        push_header();
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("lat_busy", {31'd0, busy_a}, 32'd1);
        check("lat_sck0", {31'd0, sck_a}, 32'd0);
        @(posedge clk); #1;
        check("lat_sck1", {31'd0, sck_a}, 32'd0);
        @(posedge clk); #1;
        check("lat_sck_rise", {31'd0, sck_a}, 32'd1);
        wait_done_a(3000);

        // Delayed acks: 10 cycles (overlapping the tail byte), 20 cycles (true idle gap).
        ack_delay = 10;
        @(negedge clk); push_header(); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_done_a(3000);
        ack_delay = 20;
        @(negedge clk); push_header(); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_done_a(3000);

        // Random colours and delays, with start pulses while busy.
        ack_delay = -1; fixed_data = 1'b0;
        repeat (4) begin
            @(negedge clk); push_header(); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
            repeat ($urandom_range(5, 150)) @(negedge clk);
            if (busy_a) begin start_a = 1'b1; @(negedge clk); start_a = 1'b0; end
            wait_done_a(3000);
        end

        // Reset in the middle of PIX_SEND, then a clean frame.
        @(negedge clk); push_header(); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin @(negedge clk); got = req_a; end
        for (int c = 0; c < 500 && got; c++) begin @(negedge clk); got = req_a; end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sck", {31'd0, sck_a}, 32'd0);
        check("midrst_mosi", {31'd0, mosi_a}, 32'd0);
        check("midrst_busy", {31'd0, busy_a}, 32'd0);
        check("midrst_req", {31'd0, req_a}, 32'd0);
        check("midrst_done", {31'd0, done_a}, 32'd0);
        exp_q.delete();
        exp_idx = 0;
        exp_frames_a--;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (150) begin @(negedge clk); busy_seen += int'(busy_a); end
        check("no_frame_after_reset", busy_seen, 32'd0);
        @(negedge clk); push_header(); start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_done_a(3000);

        // Auto-refresh: idle interval between frames, then start exactly at timer expiry.
        @(negedge clk);
        auto_a = 1'b1;
        push_header();
        wait_done_a(3000);
        measure_gap(1'b0, gap);
        check("refresh_gap1", gap, REF_A);
        wait_done_a(3000);
        measure_gap(1'b0, gap);
        check("refresh_gap2", gap, REF_A);
        wait_done_a(3000);
        measure_gap(1'b1, gap);
        check("refresh_gap_start", gap, REF_A);
        wait_done_a(3000);
        auto_a = 1'b0;
        busy_seen = 0;
        repeat (300) begin @(negedge clk); busy_seen += int'(busy_a); end
        check("no_frame_auto_off", busy_seen, 32'd0);
        check("frame_count_a", frames_a, exp_frames_a);

        // Long strip: total sck pulses, end-byte count, start ignored while busy.
        @(negedge clk);
        sck_cnt_b = 0;
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        repeat (100) @(negedge clk);
        check("b_busy", {31'd0, busy_b}, 32'd1);
        start_b = 1'b1; @(negedge clk); start_b = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 30000 && !got; c++) begin @(negedge clk); got = done_b; end
        check("b_done_seen", {31'd0, got}, 32'd1);
        repeat (50) @(negedge clk);
        check("b_sck_pulses", sck_cnt_b, 8 * (4 + 4 * N_B + END_B));
        check("b_tail_bytes", last_b[31:0], 32'hFFFF_FFFF);
        check("b_last_red", {24'd0, last_b[39:32]}, 32'h5A);
        check("b_frame_count", frames_b, 32'd1);
        check("b_idle", {31'd0, busy_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
